// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x480@60 timing and tile-grid constants.
// Shared by the superpixel timing generator and its pixel divider.
package vga_pkg;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOTAL =
    VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;

  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOTAL =
    VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  localparam int TILE_BITS = 5;
  localparam int GRID_W    = 20;
  localparam int GRID_H    = 15;

  localparam int CNT_W = 10;
  localparam int XSP_W = 5;
  localparam int YSP_W = 4;
  localparam int SUB_W = TILE_BITS;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   fcnt_t;

  typedef struct packed {
    logic             valid;
    logic [XSP_W-1:0] xsp;
    logic [YSP_W-1:0] ysp;
    logic [SUB_W-1:0] xsub;
    logic [SUB_W-1:0] ysub;
  } fetch_t;

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div: system clock to pixel tick divider.
// Emits a registered one-clock pulse every CLK_DIV clocks.
module pixel_tick_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixTick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Divider wraps at CLK_DIV-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Tick pulse registered off the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == LAST);
    end
  end

  assign pixTick = tick_q;

endmodule

// File: rtl/vga_superpixel_timing.sv
// vga_superpixel_timing: 640x480 beam counters, syncs and
// tile fetch coordinates running LOOKAHEAD pixels ahead.
module vga_superpixel_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int LOOKAHEAD = 2,
  parameter int H_VIS     = VGA_H_VIS,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VIS     = VGA_V_VIS,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pixTick,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             frameStart,
  output logic             fetchValid,
  output logic [XSP_W-1:0] xSupPix,
  output logic [YSP_W-1:0] ySupPix,
  output logic [SUB_W-1:0] xSub,
  output logic [SUB_W-1:0] ySub
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam cnt_t  H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t  V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t  H_VIS_C = cnt_t'(H_VIS);
  localparam cnt_t  V_VIS_C = cnt_t'(V_VIS);
  localparam cnt_t  HS_LO   = cnt_t'(H_VIS + H_FP);
  localparam cnt_t  HS_HI   = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam cnt_t  VS_LO   = cnt_t'(V_VIS + V_FP);
  localparam cnt_t  VS_HI   = cnt_t'(V_VIS + V_FP + V_SYNC - 1);
  localparam fcnt_t H_TOT_W = fcnt_t'(H_TOTAL);
  localparam fcnt_t LA_W    = fcnt_t'(LOOKAHEAD);

  logic   tick;
  cnt_t   h_q, h_d, v_q, v_d;
  logic   active_q, hs_q, vs_q, fs_q;
  fetch_t fetch_q, fetch_d;
  fcnt_t  f_sum;
  cnt_t   col, line;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .pixTick(tick)
  );

  // Beam advances one pixel per tick, wrapping line and frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Fetch point leads the beam and may spill into next line.
  always_comb begin
    f_sum = fcnt_t'(h_d) + LA_W;
    col   = f_sum[CNT_W-1:0];
    line  = v_d;
    if (f_sum >= H_TOT_W) begin
      col  = cnt_t'(f_sum - H_TOT_W);
      line = (v_d == V_LAST) ? '0 : v_d + 1'b1;
    end
    fetch_d       = '0;
    fetch_d.valid = (col < H_VIS_C) && (line < V_VIS_C);
    if (fetch_d.valid) begin
      fetch_d.xsp  = col[CNT_W-1:TILE_BITS];
      fetch_d.xsub = col[TILE_BITS-1:0];
      fetch_d.ysp  = line[TILE_BITS+YSP_W-1:TILE_BITS];
      fetch_d.ysub = line[TILE_BITS-1:0];
    end
  end

  // All decodes register on the tick edge; async clear to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q      <= '0;
      v_q      <= '0;
      active_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
      fetch_q  <= '0;
    end else begin
      fs_q <= tick && (h_d == '0) && (v_d == '0);
      if (tick) begin
        h_q      <= h_d;
        v_q      <= v_d;
        active_q <= (h_d < H_VIS_C) && (v_d < V_VIS_C);
        hs_q     <= !((h_d >= HS_LO) && (h_d <= HS_HI));
        vs_q     <= !((v_d >= VS_LO) && (v_d <= VS_HI));
        fetch_q  <= fetch_d;
      end
    end
  end

  assign pixTick    = tick;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign active     = active_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign frameStart = fs_q;
  assign fetchValid = fetch_q.valid;
  assign xSupPix    = fetch_q.xsp;
  assign ySupPix    = fetch_q.ysp;
  assign xSub       = fetch_q.xsub;
  assign ySub       = fetch_q.ysub;

endmodule

// File: tb/tb_vga_superpixel_timing.sv
// tb_vga_superpixel_timing: directed checks of the VGA superpixel
// timing generator in full-size and shrunken geometries.
module tb_vga_superpixel_timing;

  logic clk = 1'b0;
  logic rst_n;
  logic rc_n;

  logic       tk  [4];
  logic [9:0] hc  [4];
  logic [9:0] vc  [4];
  logic       act [4];
  logic       hs  [4];
  logic       vs  [4];
  logic       fs  [4];
  logic       fv  [4];
  logic [4:0] xs  [4];
  logic [3:0] ys  [4];
  logic [4:0] xb  [4];
  logic [4:0] yb  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: full size, div 2
  vga_superpixel_timing #(.CLK_DIV(2), .LOOKAHEAD(2)) u_a (
    .clk(clk), .reset(rst_n), .pixTick(tk[0]),
    .hCount(hc[0]), .vCount(vc[0]), .active(act[0]),
    .hsync(hs[0]), .vsync(vs[0]), .frameStart(fs[0]),
    .fetchValid(fv[0]), .xSupPix(xs[0]), .ySupPix(ys[0]),
    .xSub(xb[0]), .ySub(yb[0]));

  // 1: full size, div 1
  vga_superpixel_timing #(.CLK_DIV(1), .LOOKAHEAD(2)) u_b (
    .clk(clk), .reset(rst_n), .pixTick(tk[1]),
    .hCount(hc[1]), .vCount(vc[1]), .active(act[1]),
    .hsync(hs[1]), .vsync(vs[1]), .frameStart(fs[1]),
    .fetchValid(fv[1]), .xSupPix(xs[1]), .ySupPix(ys[1]),
    .xSub(xb[1]), .ySub(yb[1]));

  // 2: 80x40 frame (vis 64x36, hsync 68..75, vsync 37..38), div 2
  vga_superpixel_timing #(
    .CLK_DIV(2), .LOOKAHEAD(2),
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(36), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_c (
    .clk(clk), .reset(rc_n), .pixTick(tk[2]),
    .hCount(hc[2]), .vCount(vc[2]), .active(act[2]),
    .hsync(hs[2]), .vsync(vs[2]), .frameStart(fs[2]),
    .fetchValid(fv[2]), .xSupPix(xs[2]), .ySupPix(ys[2]),
    .xSub(xb[2]), .ySub(yb[2]));

  // 3: same small frame, div 1
  vga_superpixel_timing #(
    .CLK_DIV(1), .LOOKAHEAD(2),
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(36), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_d (
    .clk(clk), .reset(rst_n), .pixTick(tk[3]),
    .hCount(hc[3]), .vCount(vc[3]), .active(act[3]),
    .hsync(hs[3]), .vsync(vs[3]), .frameStart(fs[3]),
    .fetchValid(fv[3]), .xSupPix(xs[3]), .ySupPix(ys[3]),
    .xSub(xb[3]), .ySub(yb[3]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_hv(input int idx, input int h, input int v,
                         input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (hc[idx] == 10'(h)) && (vc[idx] == 10'(v));
    end
    chk({tag, "_reach"}, 32'(hit), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    rc_n  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rst_tick", 32'(tk[0]), 0);
    chk("rst_h", 32'(hc[0]), 0);
    chk("rst_v", 32'(vc[0]), 0);
    chk("rst_hs", 32'(hs[0]), 1);
    chk("rst_vs", 32'(vs[0]), 1);
    chk("rst_act", 32'(act[0]), 0);
    chk("rst_fs", 32'(fs[0]), 0);
    chk("rst_fv", 32'(fv[0]), 0);
    chk("rst_coords", 32'({xs[0], ys[0], xb[0], yb[0]}), 0);
    chk("rst_tick_div1", 32'(tk[1]), 0);

    rst_n = 1'b1;
    rc_n  = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("a_tick_%0d", i), 32'(tk[0]), 32'(i % 2));
      chk($sformatf("a_h_%0d", i), 32'(hc[0]), 32'(i / 2));
      if (i == 0) begin
        chk("a_pre_act", 32'(act[0]), 0);
        chk("a_pre_hs", 32'(hs[0]), 1);
        chk("a_pre_vs", 32'(vs[0]), 1);
      end
      if (i == 2) begin
        chk("a_post_act", 32'(act[0]), 1);
        chk("a_post_fv", 32'(fv[0]), 1);
        chk("a_post_xsub", 32'(xb[0]), 3);
      end
    end

    begin : hs_scan
      int bad, lo_n, lo_min, lo_max, b_low;
      bit done, exp_hs;
      bad = 0; lo_n = 0; lo_min = 1023; lo_max = 0;
      b_low = 0; done = 1'b0;
      for (int i = 0; i < 6000 && !done; i++) begin
        @(negedge clk);
        if (vc[0] == 10'd3) begin
          done = 1'b1;
        end else begin
          exp_hs = !(hc[0] >= 10'd656 && hc[0] <= 10'd751);
          if (hs[0] !== exp_hs) bad++;
          if (vs[0] !== 1'b1) bad++;
          if (!hs[0]) begin
            lo_n++;
            if (int'(hc[0]) < lo_min) lo_min = int'(hc[0]);
            if (int'(hc[0]) > lo_max) lo_max = int'(hc[0]);
          end
        end
        if (!tk[1]) b_low++;
      end
      chk("a_scan_done", 32'(done), 1);
      chk("a_hs_bad", 32'(bad), 0);
      chk("a_hs_first", 32'(lo_min), 656);
      chk("a_hs_last", 32'(lo_max), 751);
      chk("a_hs_clks", 32'(lo_n), 576);
      chk("b_tick_low", 32'(b_low), 0);
    end

    wait_hv(1, 638, 10, 20000, "b_638_10");
    chk("b_638_fv", 32'(fv[1]), 0);
    chk("b_638_coords", 32'({xs[1], ys[1], xb[1], yb[1]}), 0);
    chk("b_638_act", 32'(act[1]), 1);

    wait_hv(1, 798, 31, 20000, "b_798_31");
    chk("b_798_fv", 32'(fv[1]), 1);
    chk("b_798_xs", 32'(xs[1]), 0);
    chk("b_798_xb", 32'(xb[1]), 0);
    chk("b_798_ys", 32'(ys[1]), 1);
    chk("b_798_yb", 32'(yb[1]), 0);

    wait_hv(1, 30, 40, 10000, "b_30_40");
    chk("b_30_fv", 32'(fv[1]), 1);
    chk("b_30_xs", 32'(xs[1]), 1);
    chk("b_30_xb", 32'(xb[1]), 0);
    chk("b_30_ys", 32'(ys[1]), 1);
    chk("b_30_yb", 32'(yb[1]), 8);

    begin : frame_loop
      int tc0, tc1, td0, td1, nc, nd, vmin, vmax, fsbad;
      tc0 = 0; tc1 = 0; td0 = 0; td1 = 0; nc = 0; nd = 0;
      vmin = 1023; vmax = -1; fsbad = 0;
      for (int cyc = 0; cyc < 20000 && (nc < 2 || nd < 2); cyc++) begin
        @(negedge clk);
        if (fs[2]) begin
          if (nc == 0) tc0 = cyc;
          if (nc == 1) tc1 = cyc;
          nc++;
          if (hc[2] != 10'd0 || vc[2] != 10'd0) fsbad++;
        end
        if (fs[3]) begin
          if (nd == 0) td0 = cyc;
          if (nd == 1) td1 = cyc;
          nd++;
        end
        if (nc == 1 && !vs[2]) begin
          if (int'(vc[2]) < vmin) vmin = int'(vc[2]);
          if (int'(vc[2]) > vmax) vmax = int'(vc[2]);
        end
      end
      chk("c_frame_period", 32'(tc1 - tc0), 6400);
      chk("d_frame_period", 32'(td1 - td0), 3200);
      chk("c_fs_at_origin", 32'(fsbad), 0);
      chk("c_vs_first", 32'(vmin), 37);
      chk("c_vs_last", 32'(vmax), 38);
    end

    wait_hv(3, 78, 39, 5000, "d_78_39");
    chk("d_wrap_fv", 32'(fv[3]), 1);
    chk("d_wrap_coords", 32'({xs[3], ys[3], xb[3], yb[3]}), 0);
    chk("d_wrap_hs", 32'(hs[3]), 1);
    chk("d_wrap_vs", 32'(vs[3]), 1);

    @(negedge clk);
    rc_n = 1'b0;
    @(negedge clk);
    rc_n = 1'b1;

    wait_hv(2, 62, 5, 2000, "c_62_5");
    chk("c_62_fv", 32'(fv[2]), 0);
    chk("c_62_act", 32'(act[2]), 1);

    wait_hv(2, 78, 31, 6000, "c_78_31");
    chk("c_78_fv", 32'(fv[2]), 1);
    chk("c_78_act", 32'(act[2]), 0);
    chk("c_78_xy", 32'({xs[2], xb[2]}), 0);
    chk("c_78_ys", 32'(ys[2]), 1);
    chk("c_78_yb", 32'(yb[2]), 0);

    wait_hv(2, 72, 38, 2000, "c_72_38");
    chk("c_sync_hs_lo", 32'(hs[2]), 0);
    chk("c_sync_vs_lo", 32'(vs[2]), 0);
    #2 rc_n = 1'b0;
    #1;
    chk("c_arst_hs", 32'(hs[2]), 1);
    chk("c_arst_vs", 32'(vs[2]), 1);
    chk("c_arst_h", 32'(hc[2]), 0);
    chk("c_arst_v", 32'(vc[2]), 0);
    chk("c_arst_tick", 32'(tk[2]), 0);
    chk("c_arst_act", 32'(act[2]), 0);
    chk("c_arst_fv", 32'(fv[2]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
